// File: rtl/game_pkg.sv
// Shared gameplay types.
//   stage_e     : update-unit index, also the bit position in stage_start/stage_done.
//   seq_state_e : frame_sequencer FSM states.
//   SCREEN_H    : visible screen height in pixels.
//   next_stage  : stage that follows `cur` within one frame.
package game_pkg;

    typedef enum logic [1:0] {
        STG_PHYS    = 2'd0,
        STG_SCROLL  = 2'd1,
        STG_COLLIDE = 2'd2,
        STG_SCORE   = 2'd3
    } stage_e;

    typedef enum logic [1:0] {
        SEQ_IDLE       = 2'd0,
        SEQ_START      = 2'd1,
        SEQ_WAIT       = 2'd2,
        SEQ_FRAME_DONE = 2'd3
    } seq_state_e;

    localparam logic [9:0] SCREEN_H = 10'd480;

    // SCROLL is skipped directly from PHYS when the doodle is below the scroll line.
    // Never called with STG_SCORE; the FSM leaves the stage loop there instead.
    function automatic stage_e next_stage(input stage_e cur, input logic scroll_en);
        stage_e nxt;
        if (cur == STG_PHYS && !scroll_en) begin
            nxt = STG_COLLIDE;
        end else begin
            nxt = stage_e'(cur + 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a level that is already synchronous to Clk.
//   Clk   : clock
//   Reset : synchronous, active-high; clears the history register
//   level : input level
//   rise  : high in the cycle where level is high and was low the cycle before
module edge_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic level,
    output logic rise
);

    logic prev_r;

    // One-cycle history of the input level.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= level;
        end
    end

    assign rise = level & ~prev_r;

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: on each frame tick while the game runs, starts the update
// units in order PHYS, SCROLL, COLLIDE, SCORE and waits for each unit's done.
//   Clk, Reset     : clock, synchronous active-high reset
//   frame_clk      : frame tick level (rising edge used)
//   game_active    : game running
//   reset_game     : one-cycle clear of sequencer and statistics
//   doodle_y       : doodle vertical position, latched at frame start
//   stage_done     : per-unit done (bit = stage_e index)
//   stage_start    : one-hot one-cycle start pulse
//   busy           : frame in flight
//   frame_count    : completed frames (wraps)
//   overrun_count  : dropped frame edges (saturates)
//   timeout_err    : sticky stage-timeout flag
//   err_stage      : stage of the most recent timeout
module frame_sequencer
    import game_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter logic [9:0]  SCROLL_LINE    = 10'd200
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        game_active,
    input  logic        reset_game,
    input  logic [9:0]  doodle_y,
    input  logic [3:0]  stage_done,
    output logic [3:0]  stage_start,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [7:0]  overrun_count,
    output logic        timeout_err,
    output logic [1:0]  err_stage
);

    seq_state_e  state_r;
    seq_state_e  state_s;
    stage_e      stg_r;
    stage_e      err_stage_r;
    logic [15:0] tmr_r;
    logic        scroll_en_r;
    logic [15:0] frame_count_r;
    logic [7:0]  overrun_count_r;
    logic        timeout_err_r;
    logic        fe_s;
    logic        done_s;
    logic        timeout_hit_s;
    logic        overrun_s;
    logic        clear_s;
    logic [3:0]  stage_start_s;
    logic        busy_s;

    edge_detect u_edge_detect (
        .Clk   (Clk),
        .Reset (Reset),
        .level (frame_clk),
        .rise  (fe_s)
    );

    // reset_game clears everything except the frame_clk history.
    assign clear_s       = Reset | reset_game;
    assign done_s        = stage_done[stg_r];
    assign timeout_hit_s = (tmr_r == (TIMEOUT_CYCLES - 16'd1));
    assign overrun_s     = fe_s & game_active & (state_r != SEQ_IDLE);

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (clear_s) begin
            state_r <= SEQ_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state decode; game_active only gates starting a frame, not finishing one.
    always_comb begin
        state_s = state_r;
        case (state_r)
            SEQ_IDLE: begin
                if (fe_s && game_active) begin
                    state_s = SEQ_START;
                end else begin
                    state_s = SEQ_IDLE;
                end
            end
            SEQ_START: begin
                state_s = SEQ_WAIT;
            end
            SEQ_WAIT: begin
                if (done_s) begin
                    if (stg_r == STG_SCORE) begin
                        state_s = SEQ_FRAME_DONE;
                    end else begin
                        state_s = SEQ_START;
                    end
                end else if (timeout_hit_s) begin
                    state_s = SEQ_IDLE;
                end else begin
                    state_s = SEQ_WAIT;
                end
            end
            SEQ_FRAME_DONE: begin
                state_s = SEQ_IDLE;
            end
            default: begin
                state_s = SEQ_IDLE;
            end
        endcase
    end

    // Stage index, timeout counter and status counters.
    always_ff @(posedge Clk) begin
        if (clear_s) begin
            stg_r           <= STG_PHYS;
            tmr_r           <= 16'd0;
            scroll_en_r     <= 1'b0;
            frame_count_r   <= 16'd0;
            overrun_count_r <= 8'd0;
            timeout_err_r   <= 1'b0;
            err_stage_r     <= STG_PHYS;
        end else begin
            case (state_r)
                SEQ_IDLE: begin
                    if (fe_s && game_active) begin
                        stg_r       <= STG_PHYS;
                        scroll_en_r <= (doodle_y < SCROLL_LINE);
                    end
                end
                SEQ_START: begin
                    tmr_r <= 16'd0;
                end
                SEQ_WAIT: begin
                    if (done_s) begin
                        if (stg_r != STG_SCORE) begin
                            stg_r <= next_stage(stg_r, scroll_en_r);
                        end
                    end else if (timeout_hit_s) begin
                        timeout_err_r <= 1'b1;
                        err_stage_r   <= stg_r;
                    end else begin
                        tmr_r <= tmr_r + 16'd1;
                    end
                end
                SEQ_FRAME_DONE: begin
                    frame_count_r <= frame_count_r + 16'd1;
                end
                default: begin
                    stg_r <= STG_PHYS;
                end
            endcase
            // Edges arriving mid-frame are counted and dropped.
            if (overrun_s && (overrun_count_r != 8'hFF)) begin
                overrun_count_r <= overrun_count_r + 8'd1;
            end
        end
    end

    // Outputs decoded from the state register only.
    always_comb begin
        stage_start_s = 4'b0000;
        busy_s        = 1'b0;
        case (state_r)
            SEQ_IDLE: begin
                stage_start_s = 4'b0000;
                busy_s        = 1'b0;
            end
            SEQ_START: begin
                stage_start_s = 4'b0001 << stg_r;
                busy_s        = 1'b1;
            end
            SEQ_WAIT, SEQ_FRAME_DONE: begin
                stage_start_s = 4'b0000;
                busy_s        = 1'b1;
            end
            default: begin
                stage_start_s = 4'b0000;
                busy_s        = 1'b0;
            end
        endcase
    end

    assign stage_start   = stage_start_s;
    assign busy          = busy_s;
    assign frame_count   = frame_count_r;
    assign overrun_count = overrun_count_r;
    assign timeout_err   = timeout_err_r;
    assign err_stage     = err_stage_r;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: expected start pulses are queued when a
// frame edge is driven and popped as the DUT issues them; a small unit model
// returns done a programmable number of cycles after each start.
module tb_frame_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        game_active;
    logic        reset_game;
    logic [9:0]  doodle_y;
    logic [3:0]  stage_done;
    logic [3:0]  stage_start;
    logic        busy;
    logic [15:0] frame_count;
    logic [7:0]  overrun_count;
    logic        timeout_err;
    logic [1:0]  err_stage;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         fe_cyc = 0;
    logic [3:0] exp_q[$];
    int         lat[4];
    int         cnt[4];
    int         done_cyc[4];
    int         start_cyc[4];
    bit         sb_en;

    always #5 Clk = ~Clk;

    frame_sequencer #(
        .TIMEOUT_CYCLES (16'd16),
        .SCROLL_LINE    (10'd200)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .game_active   (game_active),
        .reset_game    (reset_game),
        .doodle_y      (doodle_y),
        .stage_done    (stage_done),
        .stage_start   (stage_start),
        .busy          (busy),
        .frame_count   (frame_count),
        .overrun_count (overrun_count),
        .timeout_err   (timeout_err),
        .err_stage     (err_stage)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs after the edge, score start pulses, update unit model.
    task automatic tick();
        logic [3:0] st;
        logic [3:0] nd;
        @(posedge Clk);
        #1;
        cyc++;
        st = stage_start;
        if (sb_en && st != 4'b0000) begin
            if (exp_q.size() > 0) chk("start_order", 32'(st), 32'(exp_q.pop_front()));
            else chk("start_unexpected", 32'(st), 32'd0);
        end
        nd = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) begin
                    nd[i] = 1'b1;
                    done_cyc[i] = cyc;
                end
            end
            if (st[i]) begin
                cnt[i] = (lat[i] > 0) ? lat[i] : -1;
                start_cyc[i] = cyc;
            end
        end
        stage_done = nd;
    endtask

    task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
        lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    endtask

    task automatic pulse_fe(input bit accept);
        frame_clk = 1'b1;
        if (accept) begin
            exp_q.push_back(4'b0001);
            if (doodle_y < 10'd200) exp_q.push_back(4'b0010);
            exp_q.push_back(4'b0100);
            exp_q.push_back(4'b1000);
        end
        fe_cyc = cyc;
        tick();
        if (accept) chk("fe_to_start", 32'(stage_start), 32'd1);
        frame_clk = 1'b0;
        tick();
    endtask

    task automatic wait_frame(input string tag, input logic [15:0] exp_fc, input int bound);
        int n;
        n = 0;
        while (n < bound && frame_count !== exp_fc) begin
            tick();
            n++;
        end
        chk({tag, "_frame_count"}, 32'(frame_count), 32'(exp_fc));
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [3:0] any_start;
        Reset = 1'b1; frame_clk = 1'b0; game_active = 1'b0; reset_game = 1'b0;
        doodle_y = 10'd100; stage_done = 4'b0000; sb_en = 1'b1;
        set_lat(3, 3, 3, 3);
        for (int i = 0; i < 4; i++) begin cnt[i] = 0; done_cyc[i] = 0; start_cyc[i] = 0; end
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        chk("rst_stage_start", 32'(stage_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_overrun", 32'(overrun_count), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_err_stage", 32'(err_stage), 32'd0);

        // Edges while the game is inactive do nothing.
        repeat (3) pulse_fe(1'b0);
        repeat (4) tick();
        chk("inactive_overrun", 32'(overrun_count), 32'd0);
        chk("inactive_busy", 32'(busy), 32'd0);
        chk("inactive_frames", 32'(frame_count), 32'd0);

        // Normal frame, all four stages.
        game_active = 1'b1;
        pulse_fe(1'b1);
        wait_frame("full", 16'd1, 100);

        // SCROLL skipped; doodle_y changed after the edge must not matter.
        doodle_y = 10'd300;
        pulse_fe(1'b1);
        doodle_y = 10'd100;
        wait_frame("skip300", 16'd2, 100);
        chk("skip_collide_after_phys", start_cyc[2] - done_cyc[0], 1);
        doodle_y = 10'd200;
        pulse_fe(1'b1);
        wait_frame("skip200", 16'd3, 100);
        doodle_y = 10'd199;
        pulse_fe(1'b1);
        wait_frame("run199", 16'd4, 100);

        // Minimum frame lengths with single-cycle units.
        set_lat(1, 1, 1, 1);
        doodle_y = 10'd100;
        pulse_fe(1'b1);
        wait_frame("min_full", 16'd5, 100);
        chk("min_full_len", cyc - fe_cyc, 10);
        doodle_y = 10'd300;
        pulse_fe(1'b1);
        wait_frame("min_skip", 16'd6, 100);
        chk("min_skip_len", cyc - fe_cyc, 8);

        // Two edges during a frame are dropped and counted.
        set_lat(10, 10, 10, 10);
        doodle_y = 10'd100;
        pulse_fe(1'b1);
        repeat (5) tick();
        pulse_fe(1'b0);
        repeat (5) tick();
        pulse_fe(1'b0);
        chk("overrun_two", 32'(overrun_count), 32'd2);
        wait_frame("overrun_frame", 16'd7, 200);

        // COLLIDE never finishes: abort 16 cycles after its start.
        set_lat(3, 3, 0, 3);
        pulse_fe(1'b1);
        k = 0;
        while (k < 100 && stage_start[2] !== 1'b1) begin tick(); k++; end
        k = 0;
        while (k < 100 && busy === 1'b1) begin tick(); k++; end
        chk("timeout_latency", k, 17);
        chk("timeout_err", 32'(timeout_err), 32'd1);
        chk("timeout_err_stage", 32'(err_stage), 32'd2);
        chk("timeout_frame_count", 32'(frame_count), 32'd7);
        chk("timeout_pending", exp_q.size(), 1);
        exp_q.delete();
        set_lat(3, 3, 3, 3);
        pulse_fe(1'b1);
        wait_frame("after_timeout", 16'd8, 100);
        chk("timeout_sticky", 32'(timeout_err), 32'd1);

        // game_active falling mid-frame does not abort the frame.
        pulse_fe(1'b1);
        tick(); tick();
        game_active = 1'b0;
        wait_frame("active_drop", 16'd9, 100);
        game_active = 1'b1;

        // Edge flood: overrun counter saturates.
        set_lat(10, 10, 10, 10);
        sb_en = 1'b0;
        for (int i = 0; i < 800; i++) begin
            frame_clk = (i % 2 == 0);
            tick();
        end
        frame_clk = 1'b0;
        k = 0;
        while (k < 200 && busy === 1'b1) begin tick(); k++; end
        chk("overrun_saturate", 32'(overrun_count), 32'd255);
        exp_q.delete();
        sb_en = 1'b1;

        // reset_game during SCROLL wait with SCROLL done in the same cycle.
        set_lat(3, 3, 3, 3);
        doodle_y = 10'd100;
        pulse_fe(1'b1);
        k = 0;
        while (k < 60 && stage_done[1] !== 1'b1) begin tick(); k++; end
        chk("rg_busy_before", 32'(busy), 32'd1);
        reset_game = 1'b1;
        exp_q.delete();
        tick();
        reset_game = 1'b0;
        chk("rg_busy", 32'(busy), 32'd0);
        chk("rg_stage_start", 32'(stage_start), 32'd0);
        chk("rg_frame_count", 32'(frame_count), 32'd0);
        chk("rg_overrun", 32'(overrun_count), 32'd0);
        chk("rg_timeout_err", 32'(timeout_err), 32'd0);
        chk("rg_err_stage", 32'(err_stage), 32'd0);
        any_start = 4'b0000;
        repeat (10) begin tick(); any_start = any_start | stage_start; end
        chk("rg_no_start", 32'(any_start), 32'd0);
        pulse_fe(1'b1);
        wait_frame("after_rg", 16'd1, 100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Per-frame scheduler for the gameplay datapath. On each rising edge of the frame tick while the game is running, it issues one start pulse to each update unit in a fixed order and waits for each unit's done before starting the next. The order is doodle physics, platform scroll, collision, score. It sits between the game-state controller (`game_active`, `reset_game`) and the update units. It also reports frame, overrun and timeout status to the debug/HEX logic.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16'd50000 — maximum WAIT cycles per stage before the frame is aborted.
- SCROLL_LINE, 10'd200 — the scroll stage runs only if the latched `doodle_y < SCROLL_LINE`.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high; clock Clk.
- frame_clk  in  1  frame tick, synchronous to Clk; only its rising edge is used.
- game_active  in  1  high while the controller is in the Game state.
- reset_game  in  1  one-cycle pulse from Game_setup.
- doodle_y  in  10  doodle vertical position, in pixels.
- stage_done  in  4  per-unit done. Bit 0 = PHYS, 1 = SCROLL, 2 = COLLIDE, 3 = SCORE.
- stage_start  out  4  one-hot, one-cycle start pulse; same bit order as `stage_done`.
- busy  out  1  high while a frame sequence is in flight.
- frame_count  out  16  number of completed frames; wraps from 0xFFFF to 0.
- overrun_count  out  8  number of dropped frame edges; saturates at 255.
- timeout_err  out  1  sticky flag, set when any stage times out.
- err_stage  out  2  index of the stage that most recently timed out.

## Operation
- **States:** IDLE, START, WAIT, FRAME_DONE. A 2-bit stage index `stg` selects the current unit.
- **Frame edge:** `fe` = `frame_clk` high AND previous-cycle `frame_clk` low.
- **IDLE:**
  - If `fe` and `game_active`: set `stg`=PHYS, latch `scroll_en` = (`doodle_y < SCROLL_LINE`, unsigned 10-bit compare), go to START.
  - Otherwise stay in IDLE.
- **START:**
  - Drive `stage_start[stg]`=1 for exactly this cycle.
  - Clear the timeout counter.
  - Go to WAIT.
- **WAIT:**
  - If `stage_done[stg]`: compute the next stage.
    - SCORE complete → go to FRAME_DONE.
    - PHYS complete with `scroll_en`=0 → `stg`=COLLIDE; SCROLL is skipped with no extra cycle.
    - Otherwise `stg`+1, go to START.
  - Else, if the counter reaches TIMEOUT_CYCLES-1: set `timeout_err`=1 and `err_stage`=`stg`, then go to IDLE (frame aborted, `frame_count` unchanged).
  - Else increment the counter.
- **FRAME_DONE:** increment `frame_count`, go to IDLE.
- **Done gating:** `stage_done` bits are ignored outside WAIT, and bits other than `stg` are ignored in WAIT.
- **Overrun:** `fe` while not in IDLE and with `game_active`=1 increments `overrun_count` (saturating). The edge is dropped, not queued.
- **Inactive edges:** `fe` with `game_active`=0 has no effect.
- **game_active falls mid-frame:** the current frame runs to completion.
- **reset_game pulse:**
  - Next cycle: state=IDLE, `frame_count`=0, `overrun_count`=0, `timeout_err`=0, `err_stage`=0. No start pulse is issued in that cycle.
  - It has priority over a simultaneous `fe` or `stage_done`.
  - The frame-edge history register is not cleared.
- **Reset:** same effect as `reset_game`; the `frame_clk` history register is also cleared to 0.

## Timing
- Reset values: `stage_start`=0, `busy`=0, `frame_count`=0, `overrun_count`=0, `timeout_err`=0, `err_stage`=0.
- All outputs are registered or decoded from the state register only; there are no combinational paths from input to output.
- If `fe` is sampled at cycle N, `stage_start[0]` is high at cycle N+1.
- `busy` is high from the first START through FRAME_DONE inclusive, and low in IDLE.
- If `stage_done` is high in WAIT at cycle M, the next `stage_start` is at M+1. After SCORE done at M, FRAME_DONE is at M+1 and `frame_count` updates at M+2.
- Minimum frame with zero-latency units: 4 stages × 2 cycles + 1 = 9 cycles; 7 cycles when SCROLL is skipped.
- Units must not assert done in the same cycle as their start pulse; such a done is lost, and the stage then times out.
- Timeout: the abort occurs TIMEOUT_CYCLES cycles after the START cycle.

## Structure
- Shared package `game_pkg`:
  - `stage_e` enum (STG_PHYS=0, STG_SCROLL=1, STG_COLLIDE=2, STG_SCORE=3).
  - `seq_state_e` enum.
  - `SCREEN_H`=480.
- One sub-module, `edge_detect`: registered rising-edge detector on `frame_clk`, with synchronous reset. Instantiate it once.
- Everything else stays in the top-level FSM.

## Test plan
- Reset, `game_active`=1, `doodle_y`=100, every unit returns done 3 cycles after its start → start pulses arrive in order 0001, 0010, 0100, 1000, and `frame_count`=1.
- `doodle_y`=300 at the frame edge → no `stage_start[1]` pulse; COLLIDE starts the cycle after PHYS done; `frame_count`=1.
- Second `fe` while in WAIT, then a third → `overrun_count`=2. Drive 300 overruns → `overrun_count` holds at 255.
- TIMEOUT_CYCLES=16, COLLIDE never done → `timeout_err`=1, `err_stage`=2, `busy`=0, `frame_count` unchanged, and the next `fe` starts a new frame normally.
- `reset_game` during WAIT of SCROLL, with SCROLL done asserted in the same cycle → next cycle IDLE, all counters 0, no further start pulse.
- `game_active`=0 with repeated `fe` → no start pulses and `overrun_count`=0. Drop `game_active` mid-frame → the frame completes and `frame_count` increments.
